// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared opcode/width constants and LSU types
package riscv_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [2:0] LS_B  = 3'b000;
  localparam logic [2:0] LS_H  = 3'b001;
  localparam logic [2:0] LS_W  = 3'b010;
  localparam logic [2:0] LS_BU = 3'b100;
  localparam logic [2:0] LS_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, REQ, WAIT_R} lsu_state_t;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        en;
  } wb_rec_t;

  // funct3[1:0] == 2'b11 has no legal width, so it always faults
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    case (funct3[1:0])
      2'b00:   is_misaligned = 1'b0;
      2'b01:   is_misaligned = addr_lo[0];
      2'b10:   is_misaligned = (addr_lo != 2'b00);
      default: is_misaligned = 1'b1;
    endcase
  endfunction

  function automatic logic [1:0] force_align(input logic [2:0] funct3, input logic [1:0] addr_lo);
    case (funct3[1:0])
      2'b00:   force_align = addr_lo;
      2'b01:   force_align = {addr_lo[1], 1'b0};
      default: force_align = 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/riscv_lsu_align.sv
// rtl/riscv_lsu_align.sv - byte-lane steering for stores and load extraction
module riscv_lsu_align
  import riscv_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [31:0] shifted;

  always_comb begin
    shifted = rdata >> {addr_lo, 3'b000};
    case (funct3[1:0])
      2'b00: begin
        be    = 4'b0001 << addr_lo;
        wdata = {4{store_data[7:0]}};
      end
      2'b01: begin
        be    = 4'b0011 << addr_lo;
        wdata = {2{store_data[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wdata = store_data;
      end
    endcase
    case (funct3)
      LS_B:    load_data = {{24{shifted[7]}}, shifted[7:0]};
      LS_H:    load_data = {{16{shifted[15]}}, shifted[15:0]};
      LS_BU:   load_data = {24'h0, shifted[7:0]};
      LS_HU:   load_data = {16'h0, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

endmodule

// File: rtl/riscv_lsu.sv
// rtl/riscv_lsu.sv - memory stage: request/grant/response FSM and writeback register
module riscv_lsu
  import riscv_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter bit TRAP_MISALIGNED = 1'b1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [6:0]            i_opcode,
  input  logic [2:0]            i_funct3,
  input  logic [31:0]           i_alu_num,
  input  logic [31:0]           i_store_data,
  input  logic [4:0]            i_rd,
  output logic                  o_mem_req,
  input  logic                  i_mem_gnt,
  output logic                  o_mem_we,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [3:0]            o_mem_be,
  output logic [31:0]           o_mem_wdata,
  input  logic                  i_mem_rvalid,
  input  logic [31:0]           i_mem_rdata,
  output logic                  o_wb_valid,
  output logic                  o_wb_en,
  output logic [4:0]            o_wb_rd,
  output logic [31:0]           o_wb_data,
  output logic                  o_misaligned
);

  lsu_state_t  state;
  wb_rec_t     wb_q;
  logic [2:0]  funct3_q;
  logic [1:0]  lo_q;
  logic [4:0]  rd_q;

  logic        accept, is_mem, trap;
  logic [2:0]  al_funct3;
  logic [1:0]  al_lo;
  logic [3:0]  al_be;
  logic [31:0] al_wdata, al_load;

  assign o_ready   = (state == IDLE);
  assign accept    = i_valid && o_ready;
  assign is_mem    = (i_opcode == OP_LOAD) || (i_opcode == OP_STORE);
  assign trap      = is_mem && TRAP_MISALIGNED && is_misaligned(i_funct3, i_alu_num[1:0]);

  // One aligner serves the request side in IDLE and the response side afterwards
  assign al_funct3 = (state == IDLE) ? i_funct3 : funct3_q;
  assign al_lo     = (state == IDLE) ? force_align(i_funct3, i_alu_num[1:0]) : lo_q;

  riscv_lsu_align u_align (
    .funct3     (al_funct3),
    .addr_lo    (al_lo),
    .store_data (i_store_data),
    .rdata      (i_mem_rdata),
    .be         (al_be),
    .wdata      (al_wdata),
    .load_data  (al_load)
  );

  assign o_wb_rd   = wb_q.rd;
  assign o_wb_data = wb_q.data;
  assign o_wb_en   = wb_q.en;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= IDLE;
      o_mem_req    <= 1'b0;
      o_mem_we     <= 1'b0;
      o_mem_addr   <= '0;
      o_mem_be     <= 4'b0;
      o_mem_wdata  <= 32'h0;
      o_wb_valid   <= 1'b0;
      o_misaligned <= 1'b0;
      wb_q         <= '0;
      funct3_q     <= 3'b0;
      lo_q         <= 2'b0;
      rd_q         <= 5'b0;
    end else begin
      o_wb_valid   <= 1'b0;
      o_misaligned <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (!is_mem) begin
              o_wb_valid <= 1'b1;
              wb_q       <= '{rd: i_rd, data: i_alu_num, en: (i_rd != 5'd0)};
            end else if (trap) begin
              o_wb_valid   <= 1'b1;
              o_misaligned <= 1'b1;
              wb_q         <= '{rd: i_rd, data: i_alu_num, en: 1'b0};
            end else begin
              o_mem_req   <= 1'b1;
              o_mem_we    <= (i_opcode == OP_STORE);
              o_mem_addr  <= {i_alu_num[ADDR_WIDTH-1:2], 2'b00};
              o_mem_be    <= al_be;
              o_mem_wdata <= al_wdata;
              funct3_q    <= i_funct3;
              lo_q        <= al_lo;
              rd_q        <= i_rd;
              state       <= REQ;
            end
          end
        end
        REQ: begin
          if (i_mem_gnt) begin
            o_mem_req <= 1'b0;
            if (o_mem_we) begin
              o_wb_valid <= 1'b1;
              wb_q       <= '{rd: rd_q, data: 32'h0, en: 1'b0};
              state      <= IDLE;
            end else if (i_mem_rvalid) begin
              o_wb_valid <= 1'b1;
              wb_q       <= '{rd: rd_q, data: al_load, en: (rd_q != 5'd0)};
              state      <= IDLE;
            end else begin
              state <= WAIT_R;
            end
          end
        end
        WAIT_R: begin
          if (i_mem_rvalid) begin
            o_wb_valid <= 1'b1;
            wb_q       <= '{rd: rd_q, data: al_load, en: (rd_q != 5'd0)};
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
